// File: rtl/multi_decade_down.sv
// Three-digit BCD down-counter with load validation, done pulse on reaching 000,
// and optional auto-reload from the last accepted load value.
module multi_decade_down #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic [3:0] load_ones,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_hundreds,
    input  logic       en,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       done,
    output logic       load_err,
    output logic       zero
);

    logic [3:0]  ones_q, ones_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  hund_q, hund_d;
    logic [11:0] reload_q, reload_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        load_ok;
    logic        at_zero;

    assign load_ok = (load_ones <= 4'd9) && (load_tens <= 4'd9) && (load_hundreds <= 4'd9);
    assign at_zero = (ones_q == 4'd0) && (tens_q == 4'd0) && (hund_q == 4'd0);

    always_comb begin
        ones_d   = ones_q;
        tens_d   = tens_q;
        hund_d   = hund_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (load) begin
            // load wins over en whether or not it is accepted
            if (load_ok) begin
                ones_d   = load_ones;
                tens_d   = load_tens;
                hund_d   = load_hundreds;
                reload_d = {load_hundreds, load_tens, load_ones};
            end else begin
                err_d = 1'b1;
            end
        end else if (en) begin
            if (!at_zero) begin
                if (ones_q != 4'd0) begin
                    ones_d = ones_q - 4'd1;
                end else begin
                    ones_d = 4'd9;
                    if (tens_q != 4'd0) begin
                        tens_d = tens_q - 4'd1;
                    end else begin
                        tens_d = 4'd9;
                        hund_d = hund_q - 4'd1;
                    end
                end
                done_d = (hund_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);
            end else if (AUTO_RELOAD) begin
                // a cleared reload register naturally keeps the value at 000
                hund_d = reload_q[11:8];
                tens_d = reload_q[7:4];
                ones_d = reload_q[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ones_q   <= 4'd0;
            tens_q   <= 4'd0;
            hund_q   <= 4'd0;
            reload_q <= 12'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ones_q   <= ones_d;
            tens_q   <= tens_d;
            hund_q   <= hund_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign ones     = ones_q;
    assign tens     = tens_q;
    assign hundreds = hund_q;
    assign done     = done_q;
    assign load_err = err_q;
    assign zero     = at_zero;

endmodule

// File: tb/tb_multi_decade_down.sv
// Directed bench for multi_decade_down: one instance without and one with
// auto-reload, driven from shared inputs.
module tb_multi_decade_down;

    logic       clk = 1'b0;
    logic       rstn;
    logic       load;
    logic [3:0] lo, lt, lh;
    logic       en;

    logic [3:0] o0, t0, h0, o1, t1, h1;
    logic       d0, e0, z0, d1, e1, z1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_decade_down #(.AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rstn(rstn), .load(load), .load_ones(lo), .load_tens(lt),
        .load_hundreds(lh), .en(en), .ones(o0), .tens(t0), .hundreds(h0),
        .done(d0), .load_err(e0), .zero(z0)
    );

    multi_decade_down #(.AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rstn(rstn), .load(load), .load_ones(lo), .load_tens(lt),
        .load_hundreds(lh), .en(en), .ones(o1), .tens(t1), .hundreds(h1),
        .done(d1), .load_err(e1), .zero(z1)
    );

    typedef struct {
        logic       ld;
        logic [3:0] lo, lt, lh;
        logic       en;
        logic [3:0] eo, et, eh;
        logic       ed, ee;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int val0();
        return h0 * 100 + t0 * 10 + o0;
    endfunction

    function automatic int val1();
        return h1 * 100 + t1 * 10 + o1;
    endfunction

    task automatic drive(input logic l, input int v, input logic e);
        load = l;
        lo = 4'(v % 10);
        lt = 4'((v / 10) % 10);
        lh = 4'(v / 100);
        en = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int v;
        int rl;
        logic exp_d;

        rstn = 1'b0;
        drive(1'b0, 0, 1'b1);
        #2;
        chk("reset_value", val0(), 0);
        chk("reset_done", d0, 0);
        chk("reset_err", e0, 0);
        chk("reset_zero", z0, 1);
        tick();
        chk("reset_hold_en", val0(), 0);
        @(negedge clk);
        rstn = 1'b1;

        // ld lo lt lh en | eo et eh ed ee
        vecs.push_back('{1, 3, 2, 1, 0, 3, 2, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 2, 2, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 2, 2, 1, 0, 0});
        vecs.push_back('{1, 0, 0, 1, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 9, 9, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 8, 9, 0, 0, 0});
        vecs.push_back('{1, 5, 5, 0, 0, 5, 5, 0, 0, 0});
        vecs.push_back('{1, 5, 5, 4'hA, 1, 5, 5, 0, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 0, 5, 5, 0, 0, 0});
        vecs.push_back('{1, 4'hF, 0, 0, 0, 5, 5, 0, 0, 1});
        vecs.push_back('{1, 1, 0, 0, 1, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 0, 1, 0, 0, 0, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 9, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 8, 0, 0, 0, 0});

        foreach (vecs[i]) begin
            load = vecs[i].ld; lo = vecs[i].lo; lt = vecs[i].lt;
            lh = vecs[i].lh;   en = vecs[i].en;
            tick();
            chk($sformatf("vec%0d_ones", i), o0, vecs[i].eo);
            chk($sformatf("vec%0d_tens", i), t0, vecs[i].et);
            chk($sformatf("vec%0d_hund", i), h0, vecs[i].eh);
            chk($sformatf("vec%0d_done", i), d0, vecs[i].ed);
            chk($sformatf("vec%0d_err", i), e0, vecs[i].ee);
            chk($sformatf("vec%0d_zero", i), z0,
                (vecs[i].eo == 0 && vecs[i].et == 0 && vecs[i].eh == 0) ? 1 : 0);
        end

        // full countdown from 123
        drive(1'b1, 123, 1'b0);
        tick();
        chk("cd_load", val0(), 123);
        drive(1'b0, 0, 1'b1);
        v = 123;
        for (int i = 1; i <= 126; i++) begin
            tick();
            if (v > 0) v--;
            exp_d = (i == 123);
            chk($sformatf("cd%0d_val", i), val0(), v);
            chk($sformatf("cd%0d_done", i), d0, exp_d);
            if (i == 124) chk("cd_ar_reload", val1(), 123);
        end

        // auto-reload from 005
        drive(1'b1, 5, 1'b0);
        tick();
        drive(1'b0, 0, 1'b1);
        v = 5;
        rl = 5;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (v == 0) begin
                v = rl;
                exp_d = 1'b0;
            end else begin
                v--;
                exp_d = (v == 0);
            end
            chk($sformatf("ar%0d_val", i), val1(), v);
            chk($sformatf("ar%0d_done", i), d1, exp_d);
        end
        chk("ar_noreload_val", val0(), 0);

        // async reset mid-count
        drive(1'b1, 47, 1'b0);
        tick();
        drive(1'b0, 0, 1'b1);
        tick();
        tick();
        chk("mid_val", val0(), 45);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_val", val0(), 0);
        chk("async_done", d0, 0);
        chk("async_zero", z0, 1);
        chk("async_val_ar", val1(), 0);
        drive(1'b1, 47, 1'b1);
        tick();
        chk("rst_ignore_load", val0(), 0);
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b0, 0, 1'b1);
        tick();
        chk("post_rst_reload_cleared", val1(), 0);
        chk("post_rst_done", d1, 0);
        drive(1'b1, 47, 1'b1);
        tick();
        chk("post_rst_load_wins", val0(), 47);
        chk("post_rst_load_err", e0, 0);
        drive(1'b0, 0, 1'b1);
        tick();
        chk("post_rst_dec", val0(), 46);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
